// File: rtl/gslcd_pixel_unpack.sv
// gslcd_pixel_unpack: pixel-clock gearbox between the framebuffer read FIFO and the LCD
// timing stage. Unpacks 32-bit framebuffer words into one 24-bit RGB pixel per transfer,
// tagging end-of-line and end-of-frame against the active area.
//
// Ports:
//   aclk, areset        clock; synchronous active-high reset
//   mode                layout: 0 RGB888 packed, 1 XRGB8888, 2 RGB565, 3 same as 1
//                       (latched on frame_start)
//   frame_start         single-cycle pulse; flushes the block and starts a frame
//   s_tdata/s_tvalid/s_tready   framebuffer word stream, byte 0 in [7:0]
//   m_pixel/m_valid/m_ready     pixel stream, first byte in [7:0]
//   m_eol, m_eof        qualify m_valid: last pixel of line / of frame
//   busy                high from frame_start until the eof pixel is accepted
//
// Optional build macro GSLCD_UNPACK_CHECK_EN adds s_tlast (in) and err_underflow
// (out, sticky until areset), flagging a word stream that ends too early or keeps
// going past its last word.

module gslcd_pixel_unpack #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned CNT_W    = 19
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [1:0]  mode,
  input  logic        frame_start,
  input  logic [31:0] s_tdata,
  input  logic        s_tvalid,
  output logic        s_tready,
`ifdef GSLCD_UNPACK_CHECK_EN
  input  logic        s_tlast,
  output logic        err_underflow,
`endif
  output logic [23:0] m_pixel,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_eol,
  output logic        m_eof,
  output logic        busy
);

  // StLast: eof pixel sits in the output register, extraction and input are frozen.
  typedef enum logic [1:0] {StIdle, StRun, StLast} state_e;

  state_e            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [63:0]       bytes_q, bytes_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [23:0]       pix_q, pix_d;
  logic              vld_q, vld_d;
  logic              eol_q, eol_d;
  logic              eof_q, eof_d;
  logic [CNT_W-1:0]  h_q, h_d;
  logic [CNT_W-1:0]  v_q, v_d;

  logic [3:0]        need;
  logic [3:0]        cons;
  logic [3:0]        cnt_rem;
  logic [63:0]       bytes_sh;
  logic [15:0]       h565;
  logic [23:0]       pix_new;
  logic              acc;
  logic              load;
  logic              eof_accept;
  logic              line_end;
  logic              frame_end;

  // Bytes needed per pixel for the latched layout; mode_q is never 3.
  always_comb begin
    need = 4'd4;
    unique case (mode_q)
      2'd0:    need = 4'd3;
      2'd2:    need = 4'd2;
      default: need = 4'd4;
    endcase
  end

  assign h565    = bytes_q[15:0];
  // RGB565 expands each field by replicating its MSBs into the low bits.
  assign pix_new = (mode_q == 2'd2) ?
                   {h565[4:0], h565[4:2], h565[10:5], h565[10:9], h565[15:11], h565[15:13]} :
                   bytes_q[23:0];

  assign s_tready   = (state_q == StRun) && (cnt_q <= 4'd4) && !frame_start;
  assign acc        = s_tvalid && s_tready;
  assign load       = (state_q == StRun) && (!vld_q || m_ready) && (cnt_q >= need) &&
                      !frame_start;
  assign eof_accept = (state_q == StLast) && vld_q && m_ready;
  assign cons       = load ? need : 4'd0;
  assign cnt_rem    = cnt_q - cons;
  assign bytes_sh   = bytes_q >> {cons, 3'b000};
  assign line_end   = (h_q == CNT_W'(H_ACTIVE - 1));
  assign frame_end  = line_end && (v_q == CNT_W'(V_ACTIVE - 1));

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    bytes_d = bytes_sh;
    cnt_d   = cnt_rem;
    pix_d   = pix_q;
    vld_d   = vld_q;
    eol_d   = eol_q;
    eof_d   = eof_q;
    h_d     = h_q;
    v_d     = v_q;

    // New word lands right after whatever survives this cycle's consumption.
    if (acc) begin
      bytes_d = bytes_sh | ({32'h0, s_tdata} << {cnt_rem, 3'b000});
      cnt_d   = cnt_rem + 4'd4;
    end

    if (vld_q && m_ready) begin
      vld_d = 1'b0;
    end

    if (load) begin
      vld_d = 1'b1;
      pix_d = pix_new;
      eol_d = line_end;
      eof_d = frame_end;
      if (line_end) begin
        h_d = '0;
        v_d = v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
      if (frame_end) begin
        state_d = StLast;
      end
    end

    // Frame complete: leftover bytes are dropped.
    if (eof_accept) begin
      state_d = StIdle;
      bytes_d = '0;
      cnt_d   = '0;
      eol_d   = 1'b0;
      eof_d   = 1'b0;
      h_d     = '0;
      v_d     = '0;
    end

    if (frame_start) begin
      state_d = StRun;
      mode_d  = (mode == 2'd3) ? 2'd1 : mode;
      bytes_d = '0;
      cnt_d   = '0;
      pix_d   = '0;
      vld_d   = 1'b0;
      eol_d   = 1'b0;
      eof_d   = 1'b0;
      h_d     = '0;
      v_d     = '0;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= StIdle;
      mode_q  <= 2'd0;
      bytes_q <= '0;
      cnt_q   <= '0;
      pix_q   <= '0;
      vld_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      bytes_q <= bytes_d;
      cnt_q   <= cnt_d;
      pix_q   <= pix_d;
      vld_q   <= vld_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
      h_q     <= h_d;
      v_q     <= v_d;
    end
  end

  assign m_pixel = pix_q;
  assign m_valid = vld_q;
  assign m_eol   = eol_q;
  assign m_eof   = eof_q;
  assign busy    = (state_q != StIdle);

`ifdef GSLCD_UNPACK_CHECK_EN
  localparam int unsigned FrameTotal = H_ACTIVE * V_ACTIVE;

  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0] remain;
  logic             last_seen_q, last_seen_d;
  logic             err_q, err_d;

  assign remain = CNT_W'(FrameTotal) - pix_cnt_q;

  always_comb begin
    pix_cnt_d   = pix_cnt_q;
    last_seen_d = last_seen_q;
    err_d       = err_q;
    if (load) begin
      pix_cnt_d = pix_cnt_q + 1'b1;
    end
    if (eof_accept) begin
      pix_cnt_d = '0;
    end
    if (acc) begin
      // Early last word, or any word after the last one.
      if ((s_tlast && (remain > CNT_W'(4))) || last_seen_q) begin
        err_d = 1'b1;
      end
      if (s_tlast) begin
        last_seen_d = 1'b1;
      end
    end
    if (frame_start) begin
      pix_cnt_d   = '0;
      last_seen_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      pix_cnt_q   <= '0;
      last_seen_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      pix_cnt_q   <= pix_cnt_d;
      last_seen_q <= last_seen_d;
      err_q       <= err_d;
    end
  end

  assign err_underflow = err_q;
`endif

endmodule

// File: tb/tb_gslcd_pixel_unpack.sv
// Self-checking bench for gslcd_pixel_unpack with a small 4x2 active area.
// Expected pixels are queued as stimulus is planned and popped by a monitor.

module tb_gslcd_pixel_unpack;

  logic        aclk = 1'b0;
  logic        areset;
  logic [1:0]  mode;
  logic        frame_start;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [23:0] m_pixel;
  logic        m_valid;
  logic        m_ready;
  logic        m_eol;
  logic        m_eof;
  logic        busy;
`ifdef GSLCD_UNPACK_CHECK_EN
  logic        s_tlast;
  logic        err_underflow;
`endif

  int          total = 0;
  int          bad   = 0;
  logic [25:0] exp_q[$];
  logic [25:0] exp_word;

  gslcd_pixel_unpack #(
    .H_ACTIVE (4),
    .V_ACTIVE (2),
    .CNT_W    (4)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .mode          (mode),
    .frame_start   (frame_start),
    .s_tdata       (s_tdata),
    .s_tvalid      (s_tvalid),
    .s_tready      (s_tready),
`ifdef GSLCD_UNPACK_CHECK_EN
    .s_tlast       (s_tlast),
    .err_underflow (err_underflow),
`endif
    .m_pixel       (m_pixel),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_eol         (m_eol),
    .m_eof         (m_eof),
    .busy          (busy)
  );

  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [23:0] p, input logic eol, input logic eof);
    exp_q.push_back({eof, eol, p});
  endtask

  function automatic logic [23:0] rgb565(input logic [15:0] h);
    logic [7:0] r, g, b;
    r = {h[15:11], h[15:13]};
    g = {h[10:5], h[10:9]};
    b = {h[4:0], h[4:2]};
    return {b, g, r};
  endfunction

  function automatic logic [7:0] seq_byte(input logic [7:0] base, input int n);
    return base + 8'(n);
  endfunction

  function automatic logic [31:0] seq_word(input logic [7:0] base, input int j);
    return {seq_byte(base, 4*j+3), seq_byte(base, 4*j+2), seq_byte(base, 4*j+1),
            seq_byte(base, 4*j)};
  endfunction

  function automatic logic [23:0] seq_pix(input logic [7:0] base, input int p);
    return {seq_byte(base, 3*p+2), seq_byte(base, 3*p+1), seq_byte(base, 3*p)};
  endfunction

  // Pixel monitor: every accepted pixel is checked against the scoreboard head.
  always @(negedge aclk) begin
    if (m_valid === 1'b1 && m_ready === 1'b1) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL sb_extra obs=%0h exp=none", {m_eof, m_eol, m_pixel});
      end
      if (exp_q.size() != 0) begin
        exp_word = exp_q.pop_front();
        chk("pixel", {6'h0, m_eof, m_eol, m_pixel}, {6'h0, exp_word});
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic fs_pulse(input logic [1:0] md);
    mode        = md;
    frame_start = 1'b1;
    @(posedge aclk);
    #1;
    frame_start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    bit got = 1'b0;
    s_tdata  = w;
    s_tvalid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge aclk);
      if (s_tready === 1'b1) begin
        got = 1'b1;
        @(posedge aclk);
        #1;
        break;
      end
      @(posedge aclk);
      #1;
    end
    s_tvalid = 1'b0;
    chk("accept", 32'(got), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge aclk);
      if (exp_q.size() == 0) break;
    end
    chk("drain", exp_q.size(), 0);
    @(posedge aclk);
    #1;
  endtask

  logic [31:0] w565 [4];
  logic [31:0] w;

  initial begin
    areset      = 1'b1;
    mode        = 2'd0;
    frame_start = 1'b0;
    s_tdata     = '0;
    s_tvalid    = 1'b0;
    m_ready     = 1'b1;
`ifdef GSLCD_UNPACK_CHECK_EN
    s_tlast     = 1'b0;
`endif
    w565 = '{32'h12345678, 32'h9ABCDEF0, 32'h0F0F00FF, 32'hF81F07E0};

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_tready", 32'(s_tready), 0);
    chk("rst_valid",  32'(m_valid), 0);
    chk("rst_pixel",  32'(m_pixel), 0);
    chk("rst_eol",    32'(m_eol), 0);
    chk("rst_eof",    32'(m_eof), 0);
    chk("rst_busy",   32'(busy), 0);
    areset = 1'b0;
    s_tvalid = 1'b1;
    @(negedge aclk);
    chk("idle_tready", 32'(s_tready), 0);
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;

    // RGB888 packed, including first-pixel latency
    fs_pulse(2'd0);
    chk("fs_busy", 32'(busy), 1);
    push(24'h020100, 1'b0, 1'b0);
    push(24'h050403, 1'b0, 1'b0);
    push(24'h080706, 1'b0, 1'b0);
    push(24'h0B0A09, 1'b1, 1'b0);
    send_word(32'h03020100);
    @(negedge aclk);
    chk("lat_k", 32'(m_valid), 0);
    @(negedge aclk);
    chk("lat_k1", 32'(m_valid), 1);
    @(posedge aclk);
    #1;
    send_word(32'h07060504);
    send_word(32'h0B0A0908);
    drain();

    // RGB565 via resync while busy
    fs_pulse(2'd2);
    @(negedge aclk);
    chk("rs1_valid", 32'(m_valid), 0);
    chk("rs1_busy", 32'(busy), 1);
    @(posedge aclk);
    #1;
    push(24'h0000FF, 1'b0, 1'b0);
    push(24'hFF0000, 1'b0, 1'b0);
    send_word(32'h001FF800);
    drain();

    // XRGB8888 full frame with mode 3; mid-frame mode change is ignored
    fs_pulse(2'd3);
    mode = 2'd0;
    for (int i = 0; i < 8; i++) begin
      w = (i == 0) ? 32'hAA123456 : {8'hAA, 8'(i * 3), 8'(i * 5), 8'(i * 7)};
      push(w[23:0], (i == 3) || (i == 7), i == 7);
    end
    for (int i = 0; i < 8; i++) begin
      w = (i == 0) ? 32'hAA123456 : {8'hAA, 8'(i * 3), 8'(i * 5), 8'(i * 7)};
      send_word(w);
      if (i == 4) chk("mid_busy", 32'(busy), 1);
    end
    drain();
    chk("eof_busy", 32'(busy), 0);
    s_tvalid = 1'b1;
    s_tdata  = 32'hDEADBEEF;
    repeat (3) begin
      @(negedge aclk);
      chk("post_tready", 32'(s_tready), 0);
      chk("post_valid", 32'(m_valid), 0);
    end
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;

    // Backpressure in RGB888
    m_ready = 1'b0;
    fs_pulse(2'd0);
    for (int p = 0; p < 8; p++) push(seq_pix(8'h40, p), (p == 3) || (p == 7), p == 7);
    send_word(seq_word(8'h40, 0));
    send_word(seq_word(8'h40, 1));
    repeat (10) begin
      @(negedge aclk);
      chk("bp_tready", 32'(s_tready), 0);
      chk("bp_valid", 32'(m_valid), 1);
      chk("bp_pixel", 32'(m_pixel), 32'(seq_pix(8'h40, 0)));
    end
    @(posedge aclk);
    #1;
    m_ready = 1'b1;
    for (int j = 2; j < 6; j++) send_word(seq_word(8'h40, j));
    drain();
    chk("bp_busy", 32'(busy), 0);

    // Resync after 5 pixels of RGB888, switching to RGB565
    fs_pulse(2'd0);
    for (int p = 0; p < 4; p++) push(seq_pix(8'h60, p), p == 3, 1'b0);
    for (int j = 0; j < 3; j++) send_word(seq_word(8'h60, j));
    drain();
    m_ready = 1'b0;
    push(seq_pix(8'h60, 4), 1'b0, 1'b0);
    send_word(seq_word(8'h60, 3));
    repeat (3) @(negedge aclk);
    chk("p5_valid", 32'(m_valid), 1);
    chk("p5_pixel", 32'(m_pixel), 32'(seq_pix(8'h60, 4)));
    @(posedge aclk);
    #1;
    fs_pulse(2'd2);
    void'(exp_q.pop_back());
    @(negedge aclk);
    chk("rs2_valid", 32'(m_valid), 0);
    chk("rs2_busy", 32'(busy), 1);
    @(posedge aclk);
    #1;
    m_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      push(rgb565(w565[j][15:0]), j == 1 ? 1'b1 : (j == 3 ? 1'b0 : 1'b0), 1'b0);
      push(rgb565(w565[j][31:16]), (j == 1) || (j == 3), j == 3);
    end
    // eol falls on pixels 3 and 7, i.e. the upper halfword of words 1 and 3.
    exp_q[2][24] = 1'b0;
    for (int j = 0; j < 4; j++) send_word(w565[j]);
    drain();
    chk("rs2_done", 32'(busy), 0);

`ifdef GSLCD_UNPACK_CHECK_EN
    // Early s_tlast in an 8-pixel XRGB frame
    chk("err_pre", 32'(err_underflow), 0);
    fs_pulse(2'd1);
    for (int i = 0; i < 8; i++) push({8'h11, 8'(i), 8'h22}, (i == 3) || (i == 7), i == 7);
    for (int i = 0; i < 8; i++) begin
      s_tlast = (i == 1);
      send_word({8'h00, 8'h11, 8'(i), 8'h22});
    end
    s_tlast = 1'b0;
    drain();
    chk("err_set", 32'(err_underflow), 1);
    fs_pulse(2'd1);
    repeat (3) @(posedge aclk);
    #1;
    chk("err_sticky", 32'(err_underflow), 1);
    areset = 1'b1;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    chk("err_clr", 32'(err_underflow), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gslcd_pixel_unpack.md
Name: gslcd_pixel_unpack

Overview:
- Pixel-clock-domain gearbox between the framebuffer read FIFO and the LCD timing/output stage.
- Converts a stream of 32-bit framebuffer words into one 24-bit RGB pixel per transfer.
- Supports packed RGB888, XRGB8888 and RGB565 layouts, selected at runtime and latched per frame.
- Counts pixels against the active area and tags end-of-line and end-of-frame.

Parameters:
- H_ACTIVE, 800, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- CNT_W, 19, pixel counter width; must satisfy 2^CNT_W > H_ACTIVE*V_ACTIVE.

Ports:
- aclk  in  1  clock; single clock domain.
- areset  in  1  synchronous, active-high reset.
- mode  in  2  layout: 0 = RGB888 packed, 1 = XRGB8888, 2 = RGB565, 3 = treated as 1.
- frame_start  in  1  single-cycle pulse; flushes the block and begins a new frame.
- s_tdata  in  32  framebuffer word; byte 0 in [7:0].
- s_tvalid  in  1  word valid.
- s_tready  out  1  word accepted when s_tvalid && s_tready.
- m_pixel  out  24  pixel; first byte in [7:0].
- m_valid  out  1  pixel valid.
- m_ready  in  1  downstream accept.
- m_eol  out  1  qualifies m_valid; last pixel of a line.
- m_eof  out  1  qualifies m_valid; last pixel of a frame.
- busy  out  1  high from frame_start until the eof pixel is accepted.

Behaviour:
- Reset: s_tready=0, m_valid=0, m_pixel=0, m_eol=0, m_eof=0, busy=0. Buffer empty, counters 0.
- Idle: s_tready=0 until frame_start. On frame_start, mode is latched into mode_q and busy=1.
- Byte buffer: 8 bytes wide with a byte count (0..8).
  - s_tready = busy && count<=4 && !frame_start.
  - An accepted word appends 4 bytes at position count.
- Pixel extraction happens when the output register is empty or being accepted (m_ready && m_valid):
  - mode_q 0: needs count>=3; pixel = bytes[2:0]; consumes 3.
  - mode_q 1: needs count>=4; pixel = bytes[2:0]; consumes 4; byte 3 dropped.
  - mode_q 2: needs count>=2; h = {b1,b0}. m_pixel[7:0] = {h[15:11],h[15:13]}, [15:8] = {h[10:5],h[10:9]}, [23:16] = {h[4:0],h[4:2]}. Consumes 2.
- Append and consume in the same cycle are allowed. New count = count + 4*acc − consumed.
- Latency: word accepted at edge k, earliest m_valid after edge k+1.
- Output register: m_pixel, m_valid, m_eol and m_eof hold stable while m_valid && !m_ready.
- Counters:
  - Pixel-in-line counter h and line counter v advance on each pixel loaded into the output register.
  - m_eol = (h==H_ACTIVE-1).
  - m_eof = m_eol && (v==V_ACTIVE-1).
- End of frame:
  - After the eof pixel is loaded, no further extraction occurs and s_tready=0.
  - When the eof pixel is accepted: remaining buffer bytes are discarded, counters clear, busy=0.
- Throughput: sustains 1 pixel/cycle in all modes while input keeps up. Mode 0 requires 3 words per 4 pixels.
- frame_start while busy (resync):
  - Buffer, output register and counters clear on that edge; m_valid=0 next cycle.
  - mode is relatched; busy stays 1.
  - No word is accepted on the frame_start cycle.
- mode changes mid-frame are ignored until the next frame_start.
- areset overrides frame_start.

Optional Feature:
- Macro: GSLCD_UNPACK_CHECK_EN.
- When defined, adds ports s_tlast (in, 1) and err_underflow (out, 1, sticky; cleared only by areset).
- err_underflow sets when either:
  - a word with s_tlast=1 is accepted while more than 4 pixels of the frame remain unextracted; or
  - a word is accepted after one carrying s_tlast, before frame_start.
- After a violation the block continues normally; the flag is diagnostic only.
- When undefined, neither port exists and behaviour is otherwise identical.

Test Plan:
- RGB888: mode=0, frame_start, feed words 0x03020100, 0x07060504, 0x0B0A0908, m_ready=1 -> pixels 0x020100, 0x050403, 0x080706, 0x0B0A09; first m_valid 2 cycles after the first accept.
- RGB565: mode=2, word 0x001FF800 -> pixel 0x0000FF then 0xFF0000; XRGB8888 word 0xAA123456 -> 0x123456.
- Backpressure: mode 0, m_ready=0 for 10 cycles mid-line -> s_tready falls once count>4; m_pixel held stable; no loss or duplication afterwards.
- Frame boundary: H_ACTIVE=4, V_ACTIVE=2, mode 1 -> m_eol on pixels 3 and 7, m_eof on 7 only; busy drops after it is accepted; further words are not accepted.
- Resync: frame_start after 5 pixels of a mode 0 frame, with mode changed to 2 -> m_valid=0 next cycle; next pixel decodes the new data as RGB565 with h,v=0.
- With GSLCD_UNPACK_CHECK_EN: s_tlast on word 2 of an 8-pixel mode 1 frame -> err_underflow=1 and it stays set until areset.
